sr_latch_pulse_ctrl: RTL and testbench
======================================

// Module: sr_latch_pulse_ctrl
// PURPOSE
//  Sequencer and arbiter for a bank of NLATCH SR latches. Up to NREQ requesters post
//  set or clear commands. A round-robin arbiter grants one command at a time and drives
//  a timed S or R pulse, then a guard gap with S=R=0. S and R are never high together,
//  so no latch ever sees the forbidden S=R=1 input.
// PARAMETERS
//  NREQ     4  number of requesters (2..8)
//  NLATCH   8  number of latches in the bank (2..16)
//  IDXW     3  latch index width; IDXW = clog2(NLATCH)
//  PULSE_W  2  cycles S or R is held high (1..15)
//  GAP_W    1  guard cycles with S=R=0 after each pulse (1..15)
// PORTS
//  clk      in   1            rising-edge clock
//  rst      in   1            synchronous, active-high reset
//  req      in   NREQ         per-requester command valid; held until gnt
//  op       in   NREQ         per-requester opcode: 1=set, 0=clear; stable while req
//  idx      in   NREQ*IDXW    per-requester target latch; requester i uses bits [i*IDXW +: IDXW]
//  gnt      out  NREQ         one-cycle pulse: command of requester i accepted
//  done     out  NREQ         one-cycle pulse: requester i's command fully complete
//  busy     out  1            high whenever state != IDLE
//  latch_s  out  NLATCH       S inputs of the latch bank
//  latch_r  out  NLATCH       R inputs of the latch bank
//  shadow_q out  NLATCH       tracked latch state (SRC_SHADOW_EN only; else 0)
// BEHAVIOUR
//  - Reset: every output is 0. State=IDLE, rr pointer=0, shadow=0. Reset wins over all
//    other events, including mid-pulse: S/R drop to 0 on the next edge; no gnt/done.
//  - FSM states are IDLE, PULSE and GAP. All outputs are registered.
//  - IDLE: if any req is high at an edge, the arbiter picks the first high req at or
//    above the pointer, wrapping from NREQ-1 to 0. It latches owner, op and idx.
//    Pointer <= (owner+1) mod NREQ. State -> PULSE. gnt[owner]=1 for exactly one cycle.
//  - PULSE: latch_s[idx] (op=1) or latch_r[idx] (op=0) is high for exactly PULSE_W
//    cycles. The first of these cycles is the gnt cycle. Then state -> GAP.
//  - GAP: S=R=0 for GAP_W cycles. done[owner]=1 in the last GAP cycle. Next state IDLE.
//  - Throughput: one command per PULSE_W+GAP_W+1 cycles, including one IDLE arbitration
//    cycle. Req edge to first S/R cycle is one cycle.
//  - Requesters may drop or change req/op/idx from the cycle after gnt. The arbiter does
//    not sample req outside IDLE.
//  - idx >= NLATCH: the command is granted and done normally, but no S/R is driven.
//  - Two requesters that target the same latch with opposite ops are serialised by the
//    round-robin order. The last pulse wins, and S/R are never simultaneous.
//  - At most one bit of latch_s|latch_r is high in any cycle.
//  - Pulse/gap counters are 4-bit and load PULSE_W-1 / GAP_W-1, counting down to 0.
// CONFIGURATION
//  SRC_SHADOW_EN defined:
//   - The block keeps shadow[NLATCH], updated at the end of each pulse, and drives
//     shadow_q from it.
//   - A granted command whose target already holds the requested value is a no-op:
//     no PULSE or GAP. State goes IDLE -> IDLE, and gnt and done pulse together in
//     the same cycle.
//  SRC_SHADOW_EN undefined:
//   - No shadow state. shadow_q ties to 0. Every command runs the full PULSE+GAP.
// TESTING (PULSE_W=2, GAP_W=1, NREQ=4 unless noted)
//  1. Reset, then req[0]=1, op=1, idx=3 -> gnt[0] next cycle. latch_s[3] high for 2
//     cycles, then 1 gap cycle with done[0]. busy is high for 3 cycles.
//  2. req[0..3] all high at once -> grants in order 0,1,2,3, spaced 4 cycles apart.
//     Repeat with the pointer at 2 -> order 2,3,0,1.
//  3. req[1] set idx=5 and req[2] clear idx=5 together -> S pulse, then R pulse.
//     Check (latch_s & latch_r)==0 in every cycle.
//  4. Assert rst in the 2nd PULSE cycle -> next cycle all outputs are 0 and state is
//     IDLE. A held req is re-granted the cycle after rst drops.
//  5. idx=9 with NLATCH=8 -> gnt/done normal, latch_s and latch_r stay 0.
//  6. SRC_SHADOW_EN: set idx=2 twice -> the first takes 4 cycles. The second gives
//     gnt[i] and done[i] in the same cycle with no pulse. shadow_q=8'h04.

Source files
------------

// File: rtl/sr_latch_pulse_ctrl_if.sv
// Requester command bus and latch-bank outputs for sr_latch_pulse_ctrl.
// Requesters drive the master side; the sequencer drives the slave side.
interface sr_latch_pulse_ctrl_if #(
    parameter int NREQ   = 4,
    parameter int NLATCH = 8,
    parameter int IDXW   = 3
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      op;
    logic [NREQ*IDXW-1:0] idx;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 busy;
    logic [NLATCH-1:0]    latch_s;
    logic [NLATCH-1:0]    latch_r;
    logic [NLATCH-1:0]    shadow_q;

    modport master (
        output req, op, idx,
        input  gnt, done, busy, latch_s, latch_r, shadow_q
    );

    modport slave (
        input  req, op, idx,
        output gnt, done, busy, latch_s, latch_r, shadow_q
    );
endinterface

// File: rtl/sr_latch_pulse_ctrl.sv
// Round-robin SR latch pulse sequencer: one timed S/R pulse plus guard gap per command.
// Optional SRC_SHADOW_EN tracks latch state and skips commands that change nothing.
module sr_latch_pulse_ctrl #(
    parameter int NREQ    = 4,
    parameter int NLATCH  = 8,
    parameter int IDXW    = 3,
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1
) (
    input logic                  clk,
    input logic                  rst,
    sr_latch_pulse_ctrl_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [3:0] PULSE_LD = 4'(PULSE_W - 1);
    localparam logic [3:0] GAP_LD   = 4'(GAP_W - 1);

    localparam logic [NREQ-1:0]   REQ_ONE = NREQ'(1);
    localparam logic [NLATCH-1:0] LAT_ONE = NLATCH'(1);

    logic [1:0]        state;
    logic [PW-1:0]     ptr;
    logic [3:0]        cnt;
    logic [NREQ-1:0]   own_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   done_q;
    logic              busy_q;
    logic [NLATCH-1:0] s_q;
    logic [NLATCH-1:0] r_q;

    logic              pick_vld;
    logic [PW-1:0]     pick;
    logic              pick_op;
    logic [IDXW-1:0]   pick_idx;
    logic [NLATCH-1:0] pick_mask;
    logic [NREQ-1:0]   pick_oh;
    logic [PW-1:0]     ptr_nxt;
    logic              noop;

    always_comb begin
        logic [PW-1:0] slot;
        pick_vld = 1'b0;
        pick     = '0;
        slot     = '0;
        for (int k = 0; k < NREQ; k++) begin
            slot = PW'((int'(ptr) + k) % NREQ);
            if (!pick_vld && bus.req[slot]) begin
                pick_vld = 1'b1;
                pick     = slot;
            end
        end
    end

    // Out-of-range idx shifts the one past the top, leaving an empty mask.
    assign pick_op   = bus.op[pick];
    assign pick_idx  = bus.idx[int'(pick)*IDXW +: IDXW];
    assign pick_mask = LAT_ONE << pick_idx;
    assign pick_oh   = REQ_ONE << pick;
    assign ptr_nxt   = (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;

`ifdef SRC_SHADOW_EN
    logic [NLATCH-1:0] shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (state == ST_PULSE && cnt == '0) begin
            shadow <= (shadow | s_q) & ~r_q;
        end
    end

    assign noop = |(pick_mask & (pick_op ? shadow : ~shadow));
    assign bus.shadow_q = shadow;
`else
    assign noop = 1'b0;
    assign bus.shadow_q = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            cnt    <= '0;
            own_q  <= '0;
            gnt_q  <= '0;
            done_q <= '0;
            busy_q <= 1'b0;
            s_q    <= '0;
            r_q    <= '0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        ptr   <= ptr_nxt;
                        own_q <= pick_oh;
                        gnt_q <= pick_oh;
                        if (noop) begin
                            done_q <= pick_oh;
                        end else begin
                            state  <= ST_PULSE;
                            busy_q <= 1'b1;
                            cnt    <= PULSE_LD;
                            s_q    <= pick_op ? pick_mask : '0;
                            r_q    <= pick_op ? '0 : pick_mask;
                        end
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        state <= ST_GAP;
                        cnt   <= GAP_LD;
                        s_q   <= '0;
                        r_q   <= '0;
                        if (GAP_LD == '0) done_q <= own_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == 4'd1) done_q <= own_q;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    s_q    <= '0;
                    r_q    <= '0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign bus.latch_s = s_q;
    assign bus.latch_r = r_q;
endmodule

// File: tb/tb_sr_latch_pulse_ctrl.sv
// Scoreboard bench for sr_latch_pulse_ctrl; IDXW=4 so idx=9 is expressible.
// Also exercises the SRC_SHADOW_EN build when that macro is defined.
module tb_sr_latch_pulse_ctrl;
    localparam int NREQ    = 4;
    localparam int NLATCH  = 8;
    localparam int IDXW    = 4;
    localparam int PULSE_W = 2;
    localparam int GAP_W   = 1;

    typedef struct {
        bit           is_done;
        logic [3:0]   vec;
        logic [7:0]   s;
        logic [7:0]   r;
        logic [7:0]   sh;
        int           dt;
        int           npulse;
        int           nbusy;
    } exp_t;

    exp_t q[$];
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_gnt = 0;
    int   npulse = 0;
    int   nbusy = 0;

    sr_latch_pulse_ctrl_if #(.NREQ(NREQ), .NLATCH(NLATCH), .IDXW(IDXW)) bus ();

    sr_latch_pulse_ctrl #(
        .NREQ(NREQ), .NLATCH(NLATCH), .IDXW(IDXW),
        .PULSE_W(PULSE_W), .GAP_W(GAP_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] shx(input logic [7:0] v);
`ifdef SRC_SHADOW_EN
        return v;
`else
        return 8'h00;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic exp_gnt(input logic [3:0] v, input logic [7:0] s,
                           input logic [7:0] r, input int dt);
        exp_t e;
        e.is_done = 1'b0; e.vec = v; e.s = s; e.r = r;
        e.sh = 8'h00; e.dt = dt; e.npulse = 0; e.nbusy = 0;
        q.push_back(e);
    endtask

    task automatic exp_done(input logic [3:0] v, input int np,
                            input int nb, input logic [7:0] sh);
        exp_t e;
        e.is_done = 1'b1; e.vec = v; e.s = 8'h00; e.r = 8'h00;
        e.sh = sh; e.dt = 0; e.npulse = np; e.nbusy = nb;
        q.push_back(e);
    endtask

    task automatic cmd(input int i, input bit o, input int ix);
        bus.op[i] = o;
        bus.idx[i*IDXW +: IDXW] = 4'(ix);
        bus.req[i] = 1'b1;
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            bus.req = bus.req & ~bus.gnt;
            n++;
        end while ((bus.req != 0 || bus.busy) && n < budget);
        if (bus.req != 0 || bus.busy) begin
            fails++;
            $display("FAIL run_idle timeout req=%b busy=%b", bus.req, bus.busy);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_gnt"}, 32'(bus.gnt), 0);
        chk({nm, "_done"}, 32'(bus.done), 0);
        chk({nm, "_busy"}, 32'(bus.busy), 0);
        chk({nm, "_s"}, 32'(bus.latch_s), 0);
        chk({nm, "_r"}, 32'(bus.latch_r), 0);
        chk({nm, "_shadow"}, 32'(bus.shadow_q), 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        checks++;
        if ((bus.latch_s & bus.latch_r) != 0 || $countones(bus.latch_s | bus.latch_r) > 1) begin
            fails++;
            $display("FAIL sr_excl s=%h r=%h", bus.latch_s, bus.latch_r);
        end
        if (bus.gnt != 0) begin
            npulse = (bus.latch_s | bus.latch_r) != 0 ? 1 : 0;
            nbusy = bus.busy ? 1 : 0;
        end else begin
            if ((bus.latch_s | bus.latch_r) != 0) npulse++;
            if (bus.busy) nbusy++;
        end
        if (bus.gnt != 0) begin
            if (q.size() == 0 || q[0].is_done) begin
                fails++; checks++;
                $display("FAIL gnt_unexpected got=%b", bus.gnt);
            end else begin
                e = q.pop_front();
                chk("gnt_vec", 32'(bus.gnt), 32'(e.vec));
                chk("gnt_s", 32'(bus.latch_s), 32'(e.s));
                chk("gnt_r", 32'(bus.latch_r), 32'(e.r));
                if (e.dt != 0) chk("gnt_spacing", cyc - last_gnt, e.dt);
            end
            last_gnt = cyc;
        end
        if (bus.done != 0) begin
            if (q.size() == 0 || !q[0].is_done) begin
                fails++; checks++;
                $display("FAIL done_unexpected got=%b", bus.done);
            end else begin
                e = q.pop_front();
                chk("done_vec", 32'(bus.done), 32'(e.vec));
                chk("done_pulse_cycles", npulse, e.npulse);
                chk("done_busy_cycles", nbusy, e.nbusy);
                chk("done_shadow", 32'(bus.shadow_q), 32'(e.sh));
            end
        end
    end

    initial begin
        int n;
        bus.req = '0;
        bus.op = '0;
        bus.idx = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // single set of latch 3
        exp_gnt(4'b0001, 8'h08, 8'h00, 0);
        exp_done(4'b0001, 2, 3, shx(8'h08));
        cmd(0, 1'b1, 3);
        run_idle(20);

        // all four at once from pointer 0
        do_reset();
        exp_gnt(4'b0001, 8'h01, 8'h00, 0); exp_done(4'b0001, 2, 3, shx(8'h01));
        exp_gnt(4'b0010, 8'h02, 8'h00, 4); exp_done(4'b0010, 2, 3, shx(8'h03));
        exp_gnt(4'b0100, 8'h04, 8'h00, 4); exp_done(4'b0100, 2, 3, shx(8'h07));
        exp_gnt(4'b1000, 8'h10, 8'h00, 4); exp_done(4'b1000, 2, 3, shx(8'h17));
        cmd(0, 1'b1, 0); cmd(1, 1'b1, 1); cmd(2, 1'b1, 2); cmd(3, 1'b1, 4);
        run_idle(40);

        // move pointer to 2, then all four again
        exp_gnt(4'b0010, 8'h00, 8'h02, 0); exp_done(4'b0010, 2, 3, shx(8'h15));
        cmd(1, 1'b0, 1);
        run_idle(20);
        exp_gnt(4'b0100, 8'h00, 8'h04, 0); exp_done(4'b0100, 2, 3, shx(8'h11));
        exp_gnt(4'b1000, 8'h00, 8'h10, 4); exp_done(4'b1000, 2, 3, shx(8'h01));
        exp_gnt(4'b0001, 8'h00, 8'h01, 4); exp_done(4'b0001, 2, 3, shx(8'h00));
        exp_gnt(4'b0010, 8'h20, 8'h00, 4); exp_done(4'b0010, 2, 3, shx(8'h20));
        cmd(0, 1'b0, 0); cmd(1, 1'b1, 5); cmd(2, 1'b0, 2); cmd(3, 1'b0, 4);
        run_idle(40);

        // opposite ops on latch 5
        do_reset();
        exp_gnt(4'b0010, 8'h20, 8'h00, 0); exp_done(4'b0010, 2, 3, shx(8'h20));
        exp_gnt(4'b0100, 8'h00, 8'h20, 4); exp_done(4'b0100, 2, 3, shx(8'h00));
        cmd(1, 1'b1, 5); cmd(2, 1'b0, 5);
        run_idle(30);

        // reset in the second pulse cycle, held req re-granted
        exp_gnt(4'b0001, 8'h40, 8'h00, 0);
        exp_gnt(4'b0001, 8'h40, 8'h00, 0);
        exp_done(4'b0001, 2, 3, shx(8'h40));
        cmd(0, 1'b1, 6);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gnt[0] !== 1'b1 && n < 8);
        chk("t4_gnt", 32'(bus.gnt), 32'h1);
        @(negedge clk);
        chk("t4_pulse2", 32'(bus.latch_s), 32'h40);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("t4_rst");
        rst = 1'b0;
        @(negedge clk);
        chk("t4_regnt", 32'(bus.gnt), 32'h1);
        bus.req[0] = 1'b0;
        run_idle(20);

        // out-of-range index
        exp_gnt(4'b1000, 8'h00, 8'h00, 0);
        exp_done(4'b1000, 0, 3, shx(8'h40));
        cmd(3, 1'b1, 9);
        run_idle(20);

        // repeated set of latch 2
        do_reset();
        exp_gnt(4'b0100, 8'h04, 8'h00, 0);
        exp_done(4'b0100, 2, 3, shx(8'h04));
        cmd(2, 1'b1, 2);
        run_idle(20);
`ifdef SRC_SHADOW_EN
        exp_gnt(4'b0100, 8'h00, 8'h00, 0);
        exp_done(4'b0100, 0, 0, 8'h04);
`else
        exp_gnt(4'b0100, 8'h04, 8'h00, 0);
        exp_done(4'b0100, 2, 3, 8'h00);
`endif
        cmd(2, 1'b1, 2);
        run_idle(20);
        chk("t6_shadow", 32'(bus.shadow_q), 32'(shx(8'h04)));

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
